// File: rtl/imm_pkg.sv
// Shared opcode constants, format tags and buffer state encoding for the
// immediate-decode stage.
package imm_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_Z     = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: classifies the opcode and builds the
// sign- or zero-extended immediate at XLEN width.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_raw;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];

    // w_raw is already extended to 32 bits; zero-extended formats keep bit 31
    // clear, so widening by bit 31 is correct for every format.
    always_comb begin
        w_raw   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (w_opcode)
            OP_LOAD, OP_JALR: begin
                fmt   = FMT_I;
                w_raw = {{20{inst[31]}}, inst[31:20]};
            end
            OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    fmt   = FMT_SHAMT;
                    w_raw = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
                end else begin
                    fmt   = FMT_I;
                    w_raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_STORE: begin
                fmt   = FMT_S;
                w_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                w_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                w_raw = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                w_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                if (w_funct3[2]) begin
                    fmt   = FMT_Z;
                    w_raw = {27'b0, inst[19:15]};
                end
            end
            OP_OP, OP_FENCE: begin
                fmt = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm       = {XLEN{w_raw[31]}};
        imm[31:0] = w_raw;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer (M main, K skid)
// and a precomputed PC-relative target.
//
// state     | meaning
// BUF_EMPTY | no entry held, out_valid low
// BUF_ONE   | M holds the oldest entry, K empty
// BUF_FULL  | M and K both hold entries, in_ready low
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    buf_state_e r_state;
    buf_state_e w_state_nxt;
    logic       r_in_ready;
    entry_t     r_m;
    entry_t     r_k;
    entry_t     w_new;

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_out_valid;
    logic            w_ld_m_new;
    logic            w_ld_m_skid;
    logic            w_ld_k;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst    (in_inst),
        .imm     (w_imm),
        .fmt     (w_fmt),
        .illegal (w_illegal)
    );

    always_comb begin
        w_new.imm     = w_imm;
        w_new.target  = in_pc + w_imm;
        w_new.pc      = in_pc;
        w_new.fmt     = w_fmt;
        w_new.illegal = w_illegal;
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = w_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BUF_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != BUF_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            unique case (r_state)
                BUF_EMPTY: if (w_in_xfer) w_state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_state_nxt = BUF_FULL;
                    else if (!w_in_xfer && w_out_xfer) w_state_nxt = BUF_EMPTY;
                end
                BUF_FULL:  if (w_out_xfer) w_state_nxt = BUF_ONE;
                default:   w_state_nxt = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid = (r_state != BUF_EMPTY);
        w_ld_m_new  = 1'b0;
        w_ld_m_skid = 1'b0;
        w_ld_k      = 1'b0;
        if (!flush) begin
            unique case (r_state)
                BUF_EMPTY: w_ld_m_new = w_in_xfer;
                BUF_ONE: begin
                    w_ld_m_new = w_in_xfer && w_out_xfer;
                    w_ld_k     = w_in_xfer && !w_out_xfer;
                end
                BUF_FULL:  w_ld_m_skid = w_out_xfer;
                default:   w_ld_m_new = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m <= '0;
            r_k <= '0;
        end else begin
            if (w_ld_m_new)       r_m <= w_new;
            else if (w_ld_m_skid) r_m <= r_k;
            if (w_ld_k)           r_k <= w_new;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_imm     = r_m.imm;
    assign out_fmt     = r_m.fmt;
    assign out_target  = r_m.target;
    assign out_pc      = r_m.pc;
    assign out_illegal = r_m.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a vector table streamed through both an
// XLEN=32 and an XLEN=64 instance, plus backpressure, flush and reset sequences.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_target64, out_pc64;
    logic [2:0]  out_fmt64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_target(out_target), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_pc({32'b0, in_pc}),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_target(out_target64), .out_pc(out_pc64), .out_illegal(out_illegal64)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic [31:0] target;
        logic        illegal;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093;

    initial begin
        vecs[0]  = '{"lui",    32'h123450B7, 32'h0000, 32'h12345000, 64'h0000000012345000, 3'd4, 32'h12345000, 1'b0};
        vecs[1]  = '{"jal",    32'hFFDFF0EF, 32'h0200, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5, 32'h000001FC, 1'b0};
        vecs[2]  = '{"srai",   32'h40315093, 32'h0204, 32'h00000003, 64'h0000000000000003, 3'd6, 32'h00000207, 1'b0};
        vecs[3]  = '{"beq",    32'h00000463, 32'h0100, 32'h00000008, 64'h0000000000000008, 3'd3, 32'h00000108, 1'b0};
        vecs[4]  = '{"addi",   32'hFFF00093, 32'h0010, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'h0000000F, 1'b0};
        vecs[5]  = '{"sw",     32'hFE112E23, 32'h0020, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 32'h0000001C, 1'b0};
        vecs[6]  = '{"csrrwi", 32'h300FD073, 32'h0030, 32'h0000001F, 64'h000000000000001F, 3'd7, 32'h0000004F, 1'b0};
        vecs[7]  = '{"add",    32'h002081B3, 32'h0040, 32'h00000000, 64'h0000000000000000, 3'd0, 32'h00000040, 1'b0};
        vecs[8]  = '{"auipc",  32'hFFFFF117, 32'h1000, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd4, 32'h00000000, 1'b0};
        vecs[9]  = '{"jalr",   32'h00008067, 32'h0050, 32'h00000000, 64'h0000000000000000, 3'd1, 32'h00000050, 1'b0};
        vecs[10] = '{"illeg",  32'h0000007F, 32'h0060, 32'h00000000, 64'h0000000000000000, 3'd0, 32'h00000060, 1'b1};
        vecs[11] = '{"slli25", 32'h02009093, 32'h0070, 32'h00000000, 64'h0000000000000020, 3'd6, 32'h00000070, 1'b0};
        vecs[12] = '{"ecall",  32'h00000073, 32'h0080, 32'h00000000, 64'h0000000000000000, 3'd0, 32'h00000080, 1'b0};
        vecs[13] = '{"lw",     32'h80002083, 32'h0900, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 32'h00000100, 1'b0};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_target", out_target, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fmt", out_fmt, 3'd0);
        chk("rst_illegal", out_illegal, 1'b0);

        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Back-to-back stream with out_ready high: one result per cycle.
        @(negedge clk) out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc);
            @(posedge clk) #1;
            chk({vecs[i].name, "_valid"}, out_valid, 1'b1);
            chk({vecs[i].name, "_ready"}, in_ready, 1'b1);
            chk({vecs[i].name, "_imm"}, out_imm, vecs[i].imm);
            chk({vecs[i].name, "_fmt"}, out_fmt, vecs[i].fmt);
            chk({vecs[i].name, "_target"}, out_target, vecs[i].target);
            chk({vecs[i].name, "_pc"}, out_pc, vecs[i].pc);
            chk({vecs[i].name, "_illegal"}, out_illegal, vecs[i].illegal);
            chk({vecs[i].name, "_imm64"}, out_imm64, vecs[i].imm64);
            chk({vecs[i].name, "_fmt64"}, out_fmt64, vecs[i].fmt);
            chk({vecs[i].name, "_target64"}, out_target64, {32'b0, vecs[i].pc} + vecs[i].imm64);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0);
        @(posedge clk) #1;
        chk("drain_valid", out_valid, 1'b0);

        // Backpressure: A, B accepted, C held while out_ready low for 3 edges.
        @(negedge clk) out_ready = 1'b0; drive(1'b1, ADDI, 32'hA00);
        @(posedge clk) #1;
        chk("bp_a_ready", in_ready, 1'b1);
        @(negedge clk) drive(1'b1, ADDI, 32'hB00);
        @(posedge clk) #1;
        chk("bp_full_ready", in_ready, 1'b0);
        chk("bp_hold_a1", out_pc, 32'hA00);
        @(negedge clk) drive(1'b1, ADDI, 32'hC00);
        @(posedge clk) #1;
        chk("bp_c_held_ready", in_ready, 1'b0);
        chk("bp_hold_a2", out_pc, 32'hA00);
        chk("bp_hold_imm", out_imm, 32'hFFFFFFFF);
        chk("bp_hold_valid", out_valid, 1'b1);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk) #1;
        chk("bp_out_b", out_pc, 32'hB00);
        chk("bp_ready_back", in_ready, 1'b1);
        @(posedge clk) #1;
        chk("bp_out_c", out_pc, 32'hC00);
        chk("bp_out_c_valid", out_valid, 1'b1);
        @(negedge clk) drive(1'b0, 32'h0, 32'h0);
        @(posedge clk) #1;
        chk("bp_empty", out_valid, 1'b0);

        // Flush with buffer FULL and a simultaneous input offer.
        @(negedge clk) out_ready = 1'b0; drive(1'b1, ADDI, 32'hD00);
        @(posedge clk);
        @(negedge clk) drive(1'b1, ADDI, 32'hD10);
        @(posedge clk) #1;
        chk("fl_full_ready", in_ready, 1'b0);
        @(negedge clk) flush = 1'b1; drive(1'b1, ADDI, 32'hD20);
        @(posedge clk) #1;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ready", in_ready, 1'b1);
        @(negedge clk) flush = 1'b0; out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0);
        @(posedge clk) #1;
        chk("fl_no_ghost", out_valid, 1'b0);
        @(negedge clk) drive(1'b1, 32'h00000463, 32'hE00);
        @(posedge clk) #1;
        chk("fl_new_valid", out_valid, 1'b1);
        chk("fl_new_pc", out_pc, 32'hE00);
        chk("fl_new_target", out_target, 32'hE08);

        // Reset mid-stream: async drop of out_valid, nothing emerges after release.
        @(negedge clk) out_ready = 1'b0; drive(1'b1, ADDI, 32'hF00);
        @(posedge clk) #1;
        chk("mr_pre_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mr_async_valid", out_valid, 1'b0);
        chk("mr_async_ready", in_ready, 1'b0);
        @(negedge clk) rst = 1'b0; out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("mr_after_valid", out_valid, 1'b0);
        chk("mr_after_ready", in_ready, 1'b1);
        chk("mr_after_pc", out_pc, 32'h0);
        @(negedge clk) drive(1'b1, 32'h0000007F, 32'h40);
        @(posedge clk) #1;
        chk("mr_new_valid", out_valid, 1'b1);
        chk("mr_new_illegal", out_illegal, 1'b1);
        chk("mr_new_imm", out_imm, 32'h0);
        @(negedge clk) drive(1'b0, 32'h0, 32'h0);
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
